// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: two-digit scan driver for sseg1 with synchronized, frame-aligned digit loads
module sseg_scan_ctrl #(
  parameter int REFRESH_COUNT = 100000,
  parameter int CW = $clog2(REFRESH_COUNT)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] A_raw,
  input  logic [3:0] B_raw,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       sel,
  output logic       frame_tick
);
  localparam logic [0:0] SHOW_A = 1'b0;
  localparam logic [0:0] SHOW_B = 1'b1;
  logic [7:0] s1, s2;
  logic [CW-1:0] cnt;
  logic term, frame_end;
  assign term = en && cnt == CW'(REFRESH_COUNT - 1);
  assign frame_end = term && sel == SHOW_B;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      cnt <= '0;
      sel <= SHOW_A;
      A <= '0;
      B <= '0;
      frame_tick <= 1'b0;
    end else begin
      s1 <= {A_raw, B_raw};
      s2 <= s1;
      cnt <= en ? (term ? '0 : cnt + 1'b1) : cnt;
      sel <= term ? ~sel : sel;
      frame_tick <= frame_end;
      {A, B} <= frame_end ? s2 : {A, B};
    end
  end
endmodule
